vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the 640x480 @ 60 Hz VGA raster timing in the vga_clk (25 MHz pixel clock) domain.
- Produces the DrawX/DrawY scan coordinates that the sprite/board renderers consume, plus hs/vs syncs and a display-enable.
- Sits upstream of every renderer and the final colour mux; it is the coordinate source those blocks sample.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, level of hs/vs while in the sync pulse

Ports:
- vga_clk  in  1  pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- display_on  out  1  high when DrawX<H_VISIBLE and DrawY<V_VISIBLE
- line_start  out  1  one-cycle pulse when DrawX==0
- frame_start  out  1  one-cycle pulse when DrawX==0 and DrawY==0
- frame_cnt  out  8  frame counter; present only with VGA_FRAME_COUNT_EN

Behaviour:
- H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must be ≤1024; violating this is an elaboration error.
- Reset (asynchronous, reset_n=0):
  - DrawX=0, DrawY=0.
  - hs=vs=~SYNC_ACTIVE.
  - display_on=0, line_start=0, frame_start=0, frame_cnt=0.
- Counting, every rising edge with reset_n=1:
  - hc increments.
  - When hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - When vc==V_TOTAL-1 and hc wraps, vc wraps to 0.
- All outputs are registered and are decoded from the *next* counter values. DrawX/DrawY, hs, vs, display_on and the pulses are therefore coherent in the same cycle, with zero relative skew.
- Sync windows:
  - hs=SYNC_ACTIVE iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs=SYNC_ACTIVE iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491), for the full line width.
- Blanking: DrawX/DrawY continue counting through blanking and expose raw counts up to 799/524. Consumers range-check or use display_on.
- First cycle after reset release: the first edge advances to DrawX=1, DrawY=0 with display_on=1. Pixel (0,0) and frame_start appear first at the next frame wrap. This is intentional: no special-case start state.
- Reset mid-frame: asynchronously forces the reset values. Timing restarts as above, with no partial-line recovery.
- No enable or stall input: the counter free-runs and never holds.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - Port frame_cnt[7:0] exists.
  - It increments in the same cycle frame_start asserts, so frame_cnt updates coincident with the (0,0) pixel.
  - Wraps 255→0. Reset value 0.
  - Used for blink/animation timing of the selection cursor.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package vga_pkg holds:
  - default timing localparams H_VISIBLE..V_BACK, H_TOTAL, V_TOTAL;
  - COORD_W=10;
  - derived sync start/end constants;
  - typedef coord_t (logic [COORD_W-1:0]).
- Sub-module mod_counter (parameter MOD; ports clk, reset_n, inc, wrap, count) is instantiated twice:
  - horizontal: inc tied high;
  - vertical: inc = horizontal wrap.
- Sync/enable decode stays in the top module.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles → DrawX=0, DrawY=0, hs=vs=1, display_on=0, pulses 0. Release → next edge gives DrawX=1, DrawY=0, display_on=1.
- Horizontal sync: run one line → hs=0 exactly for DrawX 656..751 (96 cycles); display_on falls at DrawX=640; after DrawX=799 comes DrawX=0 with DrawY incremented and line_start=1 for one cycle.
- Vertical sync: run to line 489→490 → vs=0 from (0,490) through (799,491), i.e. 1600 cycles, then 1.
- Frame wrap: at (799,524) the next cycle is (0,0) with frame_start=1, display_on=1; the frame period measured between frame_start pulses is exactly 420000 cycles.
- Reset mid-frame: assert reset_n=0 asynchronously at (300,200) between edges → outputs go to reset values immediately without waiting for a clock edge; after release, timing is identical to the first scenario.
- With VGA_FRAME_COUNT_EN: run 257 frames → frame_cnt follows 1..255, 0, 1, stepping exactly on frame_start cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA raster constants for 640x480 @ 60 Hz with a 25 MHz pixel clock.
// Holds the default porch/sync/visible sizes, the derived totals and sync
// window bounds, the scan-coordinate type and a small window-test helper.
// Imported by vga_timing_gen and mod_counter.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are half-open: [START, END)
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi
  function automatic logic inWindow(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Modulo-MOD up-counter used for the horizontal and vertical scan positions.
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset (count -> 0)
//   inc     in   advance by one on this edge
//   wrap    out  combinational: inc is high and count is at MOD-1, so the
//                next edge returns count to 0
//   count   out  registered count, 0..MOD-1
// ---------------------------------------------------------------------------
module mod_counter
  import vga_pkg::*;
#(
  parameter int MOD = 800
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   inc,
  output logic   wrap,
  output coord_t count
);

  localparam coord_t LAST = coord_t'(MOD - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator in the pixel-clock domain. Free-running
// horizontal/vertical counters provide DrawX/DrawY; syncs, display enable and
// the line/frame pulses are registered from the counters' next values so that
// every output refers to the same pixel in the same cycle.
// Ports:
//   vga_clk     in   pixel clock
//   reset_n     in   asynchronous active-low reset
//   DrawX       out  horizontal count 0..H_TOTAL-1
//   DrawY       out  vertical count 0..V_TOTAL-1
//   hs, vs      out  syncs, SYNC_ACTIVE inside the sync window
//   display_on  out  DrawX < H_VISIBLE and DrawY < V_VISIBLE
//   line_start  out  high while DrawX == 0 (not in reset)
//   frame_start out  high while DrawX == 0 and DrawY == 0 (not in reset)
//   frame_cnt   out  8-bit frame counter, only with VGA_FRAME_COUNT_EN
// Optional feature macro: VGA_FRAME_COUNT_EN
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int   H_FRONT     = vga_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BACK      = vga_pkg::H_BACK,
  parameter int   V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int   V_FRONT     = vga_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BACK      = vga_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  output vga_pkg::coord_t DrawX,
  output vga_pkg::coord_t DrawY,
  output logic            hs,
  output logic            vs,
  output logic            display_on,
  output logic            line_start,
`ifdef VGA_FRAME_COUNT_EN
  output logic            frame_start,
  output logic [7:0]      frame_cnt
`else
  output logic            frame_start
`endif
);

  import vga_pkg::*;

  localparam int H_TOT      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int L_HS_START = H_VISIBLE + H_FRONT;
  localparam int L_HS_END   = L_HS_START + H_SYNC;
  localparam int L_VS_START = V_VISIBLE + V_FRONT;
  localparam int L_VS_END   = L_VS_START + V_SYNC;

  // The counters are COORD_W bits wide, so larger totals cannot be represented
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_timingTooLarge
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  coord_t w_hCount;
  coord_t w_vCount;
  logic   w_hWrap;
  logic   w_vWrap;
  coord_t w_hNext;
  coord_t w_vNext;

  logic   r_hs;
  logic   r_vs;
  logic   r_displayOn;
  logic   r_lineStart;
  logic   r_frameStart;

  mod_counter #(.MOD(H_TOT)) u_hCounter (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .inc     (1'b1),
    .wrap    (w_hWrap),
    .count   (w_hCount)
  );

  // The vertical counter only moves at the end of each line
  mod_counter #(.MOD(V_TOT)) u_vCounter (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .inc     (w_hWrap),
    .wrap    (w_vWrap),
    .count   (w_vCount)
  );

  // Position the counters will hold after this edge; the decoded outputs are
  // registered from it so they line up with DrawX/DrawY.
  assign w_hNext = w_hWrap ? '0 : w_hCount + coord_t'(1);
  assign w_vNext = w_vWrap ? '0 : (w_hWrap ? w_vCount + coord_t'(1) : w_vCount);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs         <= ~SYNC_ACTIVE;
      r_vs         <= ~SYNC_ACTIVE;
      r_displayOn  <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_hs         <= inWindow(w_hNext, L_HS_START, L_HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vs         <= inWindow(w_vNext, L_VS_START, L_VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_displayOn  <= (w_hNext < coord_t'(H_VISIBLE)) && (w_vNext < coord_t'(V_VISIBLE));
      r_lineStart  <= (w_hNext == '0);
      r_frameStart <= (w_hNext == '0) && (w_vNext == '0);
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frameCnt;

  // Steps on the edge that enters (0,0), together with frame_start
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frameCnt <= 8'd0;
    end else if (w_vWrap) begin
      r_frameCnt <= r_frameCnt + 8'd1;
    end
  end

  assign frame_cnt = r_frameCnt;
`endif

  assign DrawX       = w_hCount;
  assign DrawY       = w_vCount;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign display_on  = r_displayOn;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Drives two instances from one clock and reset: the default 640x480 timing
// and a shrunken raster so that whole frames fit in a short run. Each cycle
// both instances are compared against an arithmetic model that derives the
// expected scan position from the number of edges since reset release.
// Optional feature macro: VGA_FRAME_COUNT_EN
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int SH_VIS = 16, SH_FP = 2, SH_SY = 3, SH_BP = 3;
  localparam int SV_VIS = 6,  SV_FP = 1, SV_SY = 2, SV_BP = 2;
  localparam int SH_TOT = SH_VIS + SH_FP + SH_SY + SH_BP;
  localparam int SV_TOT = SV_VIS + SV_FP + SV_SY + SV_BP;
  localparam int SFRAME = SH_TOT * SV_TOT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int   n;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } vec_t;

  logic clk;
  logic rstN;

  logic [9:0] bigX, bigY, smallX, smallY;
  logic bigHs, bigVs, bigDe, bigLs, bigFs;
  logic smallHs, smallVs, smallDe, smallLs, smallFs;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] bigFc, smallFc;
`endif

  int   n;
  int   testsRun;
  int   testsFailed;
  vec_t vecs[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen u_big (
    .vga_clk     (clk),
    .reset_n     (rstN),
    .DrawX       (bigX),
    .DrawY       (bigY),
    .hs          (bigHs),
    .vs          (bigVs),
    .display_on  (bigDe),
    .line_start  (bigLs),
`ifdef VGA_FRAME_COUNT_EN
    .frame_start (bigFs),
    .frame_cnt   (bigFc)
`else
    .frame_start (bigFs)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE (SH_VIS), .H_FRONT (SH_FP), .H_SYNC (SH_SY), .H_BACK (SH_BP),
    .V_VISIBLE (SV_VIS), .V_FRONT (SV_FP), .V_SYNC (SV_SY), .V_BACK (SV_BP)
  ) u_small (
    .vga_clk     (clk),
    .reset_n     (rstN),
    .DrawX       (smallX),
    .DrawY       (smallY),
    .hs          (smallHs),
    .vs          (smallVs),
    .display_on  (smallDe),
    .line_start  (smallLs),
`ifdef VGA_FRAME_COUNT_EN
    .frame_start (smallFs),
    .frame_cnt   (smallFc)
`else
    .frame_start (smallFs)
`endif
  );

  // Expected outputs n edges after reset release (n == 0 means in reset)
  function automatic obs_t modelObs(int edges, int hv, int hf, int hsw, int hb,
                                    int vv, int vf, int vsw, int vb);
    obs_t o;
    int ht, vt, fr, p, x, y;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    fr = ht * vt;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (edges > 0) begin
      p = edges % fr;
      x = p % ht;
      y = p / ht;
      o.x  = 10'(x);
      o.y  = 10'(y);
      o.hs = (x >= hv + hf && x < hv + hf + hsw) ? 1'b0 : 1'b1;
      o.vs = (y >= vv + vf && y < vv + vf + vsw) ? 1'b0 : 1'b1;
      o.de = (x < hv) && (y < vv);
      o.ls = (x == 0);
      o.fs = (p == 0);
`ifdef VGA_FRAME_COUNT_EN
      o.fc = 8'((edges / fr) % 256);
`endif
    end
    return o;
  endfunction

  function automatic obs_t actBig();
    obs_t o;
    o = '0;
    o.x = bigX; o.y = bigY; o.hs = bigHs; o.vs = bigVs;
    o.de = bigDe; o.ls = bigLs; o.fs = bigFs;
`ifdef VGA_FRAME_COUNT_EN
    o.fc = bigFc;
`endif
    return o;
  endfunction

  function automatic obs_t actSmall();
    obs_t o;
    o = '0;
    o.x = smallX; o.y = smallY; o.hs = smallHs; o.vs = smallVs;
    o.de = smallDe; o.ls = smallLs; o.fs = smallFs;
`ifdef VGA_FRAME_COUNT_EN
    o.fc = smallFc;
`endif
    return o;
  endfunction

  task automatic checkOutput(string name, obs_t act, obs_t exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s n=%0d: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
               name, n, act.x, act.y, act.hs, act.vs, act.de, act.ls, act.fs, act.fc,
               exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic checkValue(string name, int act, int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s n=%0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  task automatic checkBoth(string tag);
    checkOutput({tag, "Big"}, actBig(), modelObs(n, 640, 16, 96, 48, 480, 10, 2, 33));
    checkOutput({tag, "Small"}, actSmall(),
                modelObs(n, SH_VIS, SH_FP, SH_SY, SH_BP, SV_VIS, SV_FP, SV_SY, SV_BP));
  endtask

  // Advance the given number of clock edges, sampling 1 time unit after each
  task automatic applyStimulus(int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (rstN) n++;
      checkBoth("cycle");
    end
  endtask

  // Assert reset between edges, confirm it acts immediately, then release
  task automatic resetMid(int hold);
    #2;
    rstN = 1'b0;
    n = 0;
    #1;
    checkBoth("asyncReset");
    applyStimulus(hold);
    rstN = 1'b1;
  endtask

  // Walk the default instance through the hand-derived points of its first line
  task automatic runTable();
    obs_t exp;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].n > 0 && rstN == 1'b0) rstN = 1'b1;
      while (n < vecs[i].n) applyStimulus(1);
      exp = '0;
      exp.x  = 10'(vecs[i].x);
      exp.y  = 10'(vecs[i].y);
      exp.hs = vecs[i].hs;
      exp.vs = vecs[i].vs;
      exp.de = vecs[i].de;
      exp.ls = vecs[i].ls;
      exp.fs = vecs[i].fs;
      checkOutput($sformatf("table[%0d]", i), actBig(), exp);
    end
  endtask

  initial begin
    int hsLow, lsCnt, waited, lows, framesSeen;
    logic prevVs, found;

    vecs[0]  = '{0,   0,   0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{639, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{640, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{655, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{656, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{751, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{752, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{799, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{800, 0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{801, 1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    testsRun    = 0;
    testsFailed = 0;
    n           = 0;
    rstN        = 1'b0;

    // Hold reset for five edges, then step through the first line
    applyStimulus(5);
    runTable();

    // One full line: 96 sync cycles and a single line_start pulse
    hsLow = 0;
    lsCnt = 0;
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1);
      if (bigHs == 1'b0) hsLow++;
      if (bigLs == 1'b1) lsCnt++;
    end
    checkValue("hsLowCycles", hsLow, 96);
    checkValue("lineStartPulses", lsCnt, 1);

    // Reset in the middle of a line, then the start-up sequence must repeat
    waited = 0;
    while (bigX != 10'd300 && waited < 1000) begin
      applyStimulus(1);
      waited++;
    end
    checkValue("reachX300", int'(bigX), 300);
    resetMid(5);
    n = 0;
    rstN = 1'b0;
    runTable();

    // Vertical sync on the small raster: falls at (0, V_VIS+V_FP), lasts V_SYNC lines
    prevVs = smallVs;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 2 * SFRAME) begin
      applyStimulus(1);
      waited++;
      if (prevVs == 1'b1 && smallVs == 1'b0) found = 1'b1;
      prevVs = smallVs;
    end
    checkValue("vsFallFound", int'(found), 1);
    checkValue("vsFallX", int'(smallX), 0);
    checkValue("vsFallY", int'(smallY), SV_VIS + SV_FP);
    lows = 1;
    for (int i = 0; i < SFRAME - 1; i++) begin
      applyStimulus(1);
      if (smallVs == 1'b0) lows++;
    end
    checkValue("vsLowCycles", lows, SV_SY * SH_TOT);

    // Frame period between frame_start pulses on the small raster
    waited = 0;
    while (smallFs != 1'b1 && waited < 2 * SFRAME) begin
      applyStimulus(1);
      waited++;
    end
    checkValue("frameStartFound", int'(smallFs), 1);
    checkValue("frameStartDisplayOn", int'(smallDe), 1);
    waited = 0;
    do begin
      applyStimulus(1);
      waited++;
    end while (smallFs != 1'b1 && waited < 2 * SFRAME);
    checkValue("framePeriod", waited, SFRAME);

    // Random run lengths with asynchronous resets landing at arbitrary positions
    for (int k = 0; k < 8; k++) begin
      applyStimulus(int'($urandom_range(1, 700)));
      resetMid(int'($urandom_range(1, 4)));
    end
    applyStimulus(int'($urandom_range(50, 400)));

`ifdef VGA_FRAME_COUNT_EN
    // 257 frames: frame_cnt steps on every frame_start and wraps past 255
    resetMid(2);
    framesSeen = 0;
    for (int i = 0; i < 257 * SFRAME; i++) begin
      applyStimulus(1);
      if (smallFs == 1'b1) begin
        framesSeen++;
        checkValue("frameCnt", int'(smallFc), framesSeen % 256);
      end
    end
    checkValue("framesSeen", framesSeen, 257);
`else
    framesSeen = 0;
    for (int i = 0; i < 3 * SFRAME; i++) begin
      applyStimulus(1);
      if (smallFs == 1'b1) framesSeen++;
    end
    checkValue("framesSeen", framesSeen, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
